// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core constants and the writeback result-select enum
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;

  // Result select carried from the control unit through MEM/WB into writeback.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC2 = 2'b10,
    RES_BAD = 2'b11
  } result_src_e;

endpackage

// File: rtl/regfile_core.sv
// rtl/regfile_core.sv - register array, 1 sync write, 2 async reads, optional WB_BYPASS_EN write-first bypass
module regfile_core
  import cpu_pkg::*;
#(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int NUM_REGS   = 16,
  parameter int R0_IS_ZERO = 1,
  parameter int AW         = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam bit R0Z = (R0_IS_ZERO != 0);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage: cleared on reset, one write per cycle when the commit is effective.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: array contents, optional same-cycle bypass, R0 forced to zero last.
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
`ifdef WB_BYPASS_EN
    if (we && (ra1 == waddr)) rd1 = wdata;
    if (we && (ra2 == waddr)) rd2 = wdata;
`endif
    if (R0Z && (ra1 == '0)) rd1 = '0;
    if (R0Z && (ra2 == '0)) rd2 = '0;
  end

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback result select, commit, retire counter, illegal flag (WB_BYPASS_EN passes to regfile_core)
module writeback_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int NUM_REGS   = 16,
  parameter int R0_IS_ZERO = 1,
  parameter int CNT_W      = 32,
  parameter int AW         = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite_in,
  input  logic [1:0]        resultSrc_in,
  input  logic [DATA_W-1:0] pc_plus2_in,
  input  logic [AW-1:0]     rd_in,
  input  logic [DATA_W-1:0] aluRes_in,
  input  logic [DATA_W-1:0] readData_in,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              wb_we,
  output logic [AW-1:0]     wb_rd,
  output logic [DATA_W-1:0] wb_result,
  output logic [CNT_W-1:0]  retire_count,
  output logic              illegal_src
);

  localparam bit R0Z = (R0_IS_ZERO != 0);

  result_src_e src;
  logic        bad_sel;

  assign src     = result_src_e'(resultSrc_in);
  assign bad_sel = regWrite_in && (src == RES_BAD);
  assign wb_rd   = rd_in;

  // Result mux; the illegal encoding yields zero so nothing stale leaks to forwarding.
  always_comb begin
    wb_result = '0;
    case (src)
      RES_ALU: wb_result = aluRes_in;
      RES_MEM: wb_result = readData_in;
      RES_PC2: wb_result = pc_plus2_in;
      default: wb_result = '0;
    endcase
  end

  // Effective commit: drops illegal selects, R0 writes (when hardwired) and reset cycles.
  always_comb begin
    wb_we = regWrite_in && (src != RES_BAD) && !(R0Z && (rd_in == '0)) && reset;
  end

  // Retire counter, wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (!reset)     retire_count <= '0;
    else if (wb_we) retire_count <= retire_count + CNT_W'(1);
  end

  // Sticky illegal-select flag, only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset)       illegal_src <= 1'b0;
    else if (bad_sel) illegal_src <= 1'b1;
  end

  regfile_core #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .R0_IS_ZERO(R0_IS_ZERO),
    .AW        (AW)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .we   (wb_we),
    .waddr(rd_in),
    .wdata(wb_result),
    .ra1  (ra1),
    .ra2  (ra2),
    .rd1  (rd1),
    .rd2  (rd2)
  );

endmodule
